// File: rtl/regs_wb_sched_if.sv
// Bus bundle for the write-back scheduler: issue port, two producer ports,
// the register file write port and the outstanding-write count.
interface regs_wb_sched_if;
  logic        iss_valid;
  logic [4:0]  iss_Rs1;
  logic [4:0]  iss_Rs2;
  logic [4:0]  iss_Rd;
  logic        iss_wr;
  logic        iss_ready;

  logic        alu_valid;
  logic [4:0]  alu_Rd;
  logic [31:0] alu_data;
  logic        alu_ready;

  logic        mem_valid;
  logic [4:0]  mem_Rd;
  logic [31:0] mem_data;
  logic        mem_ready;

  logic        WB;
  logic [4:0]  Rd;
  logic [31:0] reg_s;
  logic [3:0]  outstanding;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // A producer that sees ready=0 holds valid, Rd and data stable.
  modport master (
    output iss_valid, iss_Rs1, iss_Rs2, iss_Rd, iss_wr,
    output alu_valid, alu_Rd, alu_data,
    output mem_valid, mem_Rd, mem_data,
    input  iss_ready, alu_ready, mem_ready,
    input  WB, Rd, reg_s, outstanding
  );

  modport slave (
    input  iss_valid, iss_Rs1, iss_Rs2, iss_Rd, iss_wr,
    input  alu_valid, alu_Rd, alu_data,
    input  mem_valid, mem_Rd, mem_data,
    output iss_ready, alu_ready, mem_ready,
    output WB, Rd, reg_s, outstanding
  );
endinterface

// File: rtl/regs_wb_sched.sv
// Write-back arbiter (MEM over ALU with ALU anti-starvation) and busy-bit
// scoreboard gating instruction issue for the DLX register file.
module regs_wb_sched #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 3
) (
  input logic           clk,
  input logic           rst,
  regs_wb_sched_if.slave bus
);

  logic [31:0] busy;
  logic [3:0]  outstanding_q;
  logic [3:0]  starve_cnt;
  logic        wb_q;
  logic [4:0]  rd_q;
  logic [31:0] data_q;

  logic        alu_pri;
  logic        grant_mem;
  logic        grant_alu;
  logic        granted;
  logic        any_valid;
  logic [4:0]  g_rd;
  logic [31:0] g_data;
  logic        issue_wr;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;
  logic [1:0]  n_dec;
  logic signed [5:0] out_sum;
  logic [3:0]  out_next;
  logic [3:0]  starve_next;

  function automatic logic hazard(input logic [4:0] r, input logic [31:0] b);
    return b[r] && (r != 5'd0);
  endfunction

  always_comb begin
    alu_pri   = (starve_cnt >= 4'(STARVE_LIMIT));
    any_valid = bus.alu_valid || bus.mem_valid;
    grant_mem = bus.mem_valid && !(alu_pri && bus.alu_valid);
    grant_alu = bus.alu_valid && !grant_mem;
    granted   = grant_mem || grant_alu;
    g_rd      = grant_mem ? bus.mem_Rd   : bus.alu_Rd;
    g_data    = grant_mem ? bus.mem_data : bus.alu_data;
  end

  assign bus.alu_ready = grant_alu || !any_valid;
  assign bus.mem_ready = grant_mem || !any_valid;

  // Issue readiness looks only at registered state.
  assign bus.iss_ready = !hazard(bus.iss_Rs1, busy) &&
                         !hazard(bus.iss_Rs2, busy) &&
                         !(bus.iss_wr && hazard(bus.iss_Rd, busy)) &&
                         (outstanding_q < 4'(MAX_OUTSTANDING));

  always_comb begin
    issue_wr = bus.iss_valid && bus.iss_ready && bus.iss_wr;
    set_vec  = (issue_wr && bus.iss_Rd != 5'd0) ? (32'd1 << bus.iss_Rd) : 32'd0;
    clr_vec  = wb_q ? (32'd1 << rd_q) : 32'd0;
    // A commit and an r0 discard on the same edge retire two writes.
    n_dec    = {1'b0, wb_q} + {1'b0, granted && (g_rd == 5'd0)};
    out_sum  = $signed({2'b00, outstanding_q}) + $signed({5'b00000, issue_wr})
             - $signed({4'b0000, n_dec});
    out_next = (out_sum < 0) ? 4'd0 : out_sum[3:0];
    if (bus.alu_valid && !bus.alu_ready)
      starve_next = (starve_cnt == 4'd15) ? 4'd15 : starve_cnt + 4'd1;
    else
      starve_next = 4'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy          <= 32'd0;
      outstanding_q <= 4'd0;
      starve_cnt    <= 4'd0;
      wb_q          <= 1'b0;
      rd_q          <= 5'd0;
      data_q        <= 32'd0;
    end else begin
      busy          <= (busy & ~clr_vec) | set_vec;
      outstanding_q <= out_next;
      starve_cnt    <= starve_next;
      wb_q          <= granted && (g_rd != 5'd0);
      if (granted) begin
        rd_q   <= g_rd;
        data_q <= g_data;
      end
    end
  end

  assign bus.WB          = wb_q;
  assign bus.Rd          = rd_q;
  assign bus.reg_s       = data_q;
  assign bus.outstanding = outstanding_q;

endmodule

// File: tb/tb_regs_wb_sched.sv
// Directed bench for regs_wb_sched: issue/commit latency, RAW stall,
// producer conflict, ALU starvation, capacity limit with r0 and reset.
module tb_regs_wb_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  regs_wb_sched_if bus();

  regs_wb_sched #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic issue_wr(input logic [4:0] rd, input string tag);
    bus.iss_valid = 1'b1;
    bus.iss_Rd    = rd;
    bus.iss_wr    = 1'b1;
    #1;
    check(tag, bus.iss_ready, 1'b1);
    tick();
    bus.iss_valid = 1'b0;
    bus.iss_wr    = 1'b0;
    bus.iss_Rd    = 5'd0;
  endtask

  initial begin
    bus.iss_valid = 0; bus.iss_Rs1 = 0; bus.iss_Rs2 = 0; bus.iss_Rd = 0; bus.iss_wr = 0;
    bus.alu_valid = 0; bus.alu_Rd = 0; bus.alu_data = 0;
    bus.mem_valid = 0; bus.mem_Rd = 0; bus.mem_data = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_wb", bus.WB, 1'b0);
    check("rst_rd", bus.Rd, 5'd0);
    check("rst_regs", bus.reg_s, 32'd0);
    check("rst_outst", bus.outstanding, 4'd0);
    check("rst_iss_ready", bus.iss_ready, 1'b1);

    // Basic issue -> ALU result -> commit -> dependent issue
    issue_wr(5'd7, "s1_issue7");
    check("s1_outst1", bus.outstanding, 4'd1);
    bus.iss_Rs1 = 5'd7;
    #1;
    check("s1_busy7", bus.iss_ready, 1'b0);
    bus.alu_valid = 1'b1; bus.alu_Rd = 5'd7; bus.alu_data = 32'd111111;
    #1;
    check("s1_alu_ready", bus.alu_ready, 1'b1);
    tick();
    bus.alu_valid = 1'b0;
    #1;
    check("s1_wb", bus.WB, 1'b1);
    check("s1_rd", bus.Rd, 5'd7);
    check("s1_regs", bus.reg_s, 32'd111111);
    check("s1_outst_t1", bus.outstanding, 4'd1);
    check("s1_stall_t1", bus.iss_ready, 1'b0);
    tick();
    check("s1_outst_t2", bus.outstanding, 4'd0);
    check("s1_ready_t2", bus.iss_ready, 1'b1);
    check("s1_wb_t2", bus.WB, 1'b0);
    bus.iss_valid = 1'b1;
    tick();
    bus.iss_valid = 1'b0;
    bus.iss_Rs1 = 5'd0;

    // RAW stall on r3 until a load commits
    issue_wr(5'd3, "s2_issue3");
    bus.iss_valid = 1'b1; bus.iss_Rs1 = 5'd3; bus.iss_Rs2 = 5'd3;
    #1;
    check("s2_stall_a", bus.iss_ready, 1'b0);
    tick(); tick();
    check("s2_stall_b", bus.iss_ready, 1'b0);
    bus.mem_valid = 1'b1; bus.mem_Rd = 5'd3; bus.mem_data = 32'd444444;
    #1;
    check("s2_mem_ready", bus.mem_ready, 1'b1);
    check("s2_stall_c", bus.iss_ready, 1'b0);
    tick();
    bus.mem_valid = 1'b0;
    #1;
    check("s2_wb", bus.WB, 1'b1);
    check("s2_rd", bus.Rd, 5'd3);
    check("s2_regs", bus.reg_s, 32'd444444);
    check("s2_stall_d", bus.iss_ready, 1'b0);
    tick();
    check("s2_ready", bus.iss_ready, 1'b1);
    tick();
    bus.iss_valid = 1'b0; bus.iss_Rs1 = 5'd0; bus.iss_Rs2 = 5'd0;
    check("s2_outst", bus.outstanding, 4'd0);

    // ALU and MEM collide: MEM first, ALU next cycle
    issue_wr(5'd10, "s3_issue10");
    issue_wr(5'd13, "s3_issue13");
    check("s3_outst2", bus.outstanding, 4'd2);
    bus.alu_valid = 1'b1; bus.alu_Rd = 5'd10; bus.alu_data = 32'd222222;
    bus.mem_valid = 1'b1; bus.mem_Rd = 5'd13; bus.mem_data = 32'd333333;
    #1;
    check("s3_mem_ready", bus.mem_ready, 1'b1);
    check("s3_alu_wait", bus.alu_ready, 1'b0);
    tick();
    bus.mem_valid = 1'b0;
    #1;
    check("s3_wb_mem", bus.WB, 1'b1);
    check("s3_rd_mem", bus.Rd, 5'd13);
    check("s3_regs_mem", bus.reg_s, 32'd333333);
    check("s3_alu_ready", bus.alu_ready, 1'b1);
    tick();
    bus.alu_valid = 1'b0;
    #1;
    check("s3_wb_alu", bus.WB, 1'b1);
    check("s3_rd_alu", bus.Rd, 5'd10);
    check("s3_regs_alu", bus.reg_s, 32'd222222);
    check("s3_outst1", bus.outstanding, 4'd1);
    tick();
    check("s3_outst0", bus.outstanding, 4'd0);

    // Starvation: ALU forced on the 4th cycle behind continuous MEM
    bus.alu_valid = 1'b1; bus.alu_Rd = 5'd20; bus.alu_data = 32'd555555;
    bus.mem_valid = 1'b1; bus.mem_Rd = 5'd21; bus.mem_data = 32'd666666;
    for (int c = 1; c <= 3; c++) begin
      #1;
      check($sformatf("s4_alu_wait%0d", c), bus.alu_ready, 1'b0);
      check($sformatf("s4_mem_go%0d", c), bus.mem_ready, 1'b1);
      tick();
      check($sformatf("s4_regs_mem%0d", c), bus.reg_s, 32'd666666);
    end
    #1;
    check("s4_alu_forced", bus.alu_ready, 1'b1);
    check("s4_mem_held", bus.mem_ready, 1'b0);
    tick();
    bus.alu_valid = 1'b0;
    #1;
    check("s4_wb", bus.WB, 1'b1);
    check("s4_rd", bus.Rd, 5'd20);
    check("s4_regs", bus.reg_s, 32'd555555);
    bus.mem_valid = 1'b0;
    tick();
    check("s4_outst_sat", bus.outstanding, 4'd0);

    // Capacity limit, retired by an r0 result
    issue_wr(5'd1, "s5_issue1");
    issue_wr(5'd2, "s5_issue2");
    issue_wr(5'd4, "s5_issue4");
    issue_wr(5'd5, "s5_issue5");
    check("s5_outst4", bus.outstanding, 4'd4);
    bus.iss_valid = 1'b1; bus.iss_Rd = 5'd6; bus.iss_wr = 1'b1;
    #1;
    check("s5_full_a", bus.iss_ready, 1'b0);
    tick();
    check("s5_full_b", bus.iss_ready, 1'b0);
    check("s5_outst_hold", bus.outstanding, 4'd4);
    bus.mem_valid = 1'b1; bus.mem_Rd = 5'd0; bus.mem_data = 32'd777;
    #1;
    check("s5_mem_r0_ready", bus.mem_ready, 1'b1);
    tick();
    bus.mem_valid = 1'b0;
    #1;
    check("s5_r0_wb", bus.WB, 1'b0);
    check("s5_r0_outst", bus.outstanding, 4'd3);
    check("s5_ready6", bus.iss_ready, 1'b1);
    tick();
    bus.iss_valid = 1'b0; bus.iss_wr = 1'b0; bus.iss_Rd = 5'd0;
    check("s5_outst_re4", bus.outstanding, 4'd4);
    bus.alu_valid = 1'b1; bus.alu_Rd = 5'd1; bus.alu_data = 32'd1;
    tick();
    bus.alu_Rd = 5'd2; bus.alu_data = 32'd2;
    tick();
    bus.alu_valid = 1'b0;
    tick();
    check("s5_outst2", bus.outstanding, 4'd2);

    // Reset mid-operation
    bus.alu_valid = 1'b1; bus.alu_Rd = 5'd4; bus.alu_data = 32'd9;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.alu_valid = 1'b0;
    bus.iss_Rs1 = 5'd4; bus.iss_Rs2 = 5'd5; bus.iss_Rd = 5'd6; bus.iss_wr = 1'b1;
    #1;
    check("s6_wb", bus.WB, 1'b0);
    check("s6_outst", bus.outstanding, 4'd0);
    check("s6_rd", bus.Rd, 5'd0);
    check("s6_regs", bus.reg_s, 32'd0);
    check("s6_busy_clear", bus.iss_ready, 1'b1);
    tick();
    check("s6_wb_after", bus.WB, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
